somador_serial: RTL and testbench

SOMADOR_SERIAL -- requirements
Module: somador_serial

---
 rtl/somador_pkg.sv | 12 +
 rtl/somador_completo.sv | 16 +
 rtl/somador_serial.sv | 107 ++++++++++
 tb/tb_somador_serial.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/somador_pkg.sv
// Shared definitions for the serial adder/subtractor: state encoding and default width.
package somador_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/somador_completo.sv
// One-bit full adder: the per-bit sum/carry cell of the serial datapath.
module somador_completo (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum is the three-way parity, carry is the majority of the three inputs.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/somador_serial.sv
// Bit-serial adder/subtractor. One bit per clock, LSB first, through a single
// full adder. Subtraction is a + ~b + 1, with the +1 injected as the initial carry.
//
// Handshake: start is a request sampled only in IDLE; the edge that sees
// start=1 in IDLE accepts the operands and mode. busy is high for exactly
// WIDTH cycles while bits are processed, then done pulses for one cycle with
// s/cout/overflow already valid. start outside IDLE is ignored.
module somador_serial
  import somador_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output state_t           state_dbg
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  if (WIDTH < 2) begin : g_width_check
    $error("somador_serial: WIDTH must be at least 2");
  end

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_cout;

  somador_completo u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign state_dbg = state;

  // Control FSM and datapath: load operands, shift one bit per CALC cycle,
  // publish the result only on the transition into DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      result   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      s        <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          result <= {fa_s, result[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= fa_cout;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            // carry still holds the carry into the MSB here, fa_cout the carry out of it.
            s        <= {fa_s, result[WIDTH-1:1]};
            cout     <= fa_cout;
            overflow <= carry ^ fa_cout;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_somador_serial.sv
// Testbench for somador_serial (WIDTH=8): directed vectors, ignored start,
// mid-operation reset, back-to-back requests and a randomized sweep against
// an arithmetic reference model.
module tb_somador_serial;
  import somador_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] s;
  logic         cout;
  logic         overflow;
  logic         busy;
  logic         done;
  state_t       state_dbg;

  int tests;
  int fails;

  somador_serial #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .s         (s),
    .cout      (cout),
    .overflow  (overflow),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic. Returns {overflow, cout, s}.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                          input logic rsub);
    int ua, ub, ur, sa, sb, sr;
    logic [W-1:0] rs;
    logic rc, rv;
    ua = int'(ra);
    ub = int'(rb);
    sa = ua >= (1 << (W - 1)) ? ua - (1 << W) : ua;
    sb = ub >= (1 << (W - 1)) ? ub - (1 << W) : ub;
    if (rsub) begin
      ur = ua - ub;
      rc = (ua >= ub);
      sr = sa - sb;
    end else begin
      ur = ua + ub;
      rc = (ur >= (1 << W));
      sr = sa + sb;
    end
    rs = W'(ur & ((1 << W) - 1));
    rv = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
    return {rv, rc, rs};
  endfunction

  // Driver: present operands with start for one edge. Called ~1 time unit after
  // a rising edge with the DUT in IDLE; returns 1 time unit after the accepting edge.
  task automatic drive_op(input logic [W-1:0] da, input logic [W-1:0] db, input logic dsub);
    a     = da;
    b     = db;
    sub   = dsub;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Waits (bounded) for done; cyc is the cycle index after the accepting edge, -1 on timeout.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!done) cyc = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({s, cout, overflow, busy, done} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got s=%h cout=%b ovf=%b busy=%b done=%b, expected all 0",
               s, cout, overflow, busy, done);
    end
    tests++;
    if (state_dbg !== IDLE) begin
      fails++;
      $display("FAIL reset_state: got %0d expected %0d", state_dbg, IDLE);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] va[5]  = '{8'h0F, 8'hFF, 8'h7F, 8'h05, 8'h80};
    logic [W-1:0] vb[5]  = '{8'h01, 8'h01, 8'h01, 8'h07, 8'h01};
    logic         vsb[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] vs[5]  = '{8'h10, 8'h00, 8'h80, 8'hFE, 8'h7F};
    logic         vc[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic         vv[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      logic [W-1:0] s_before;
      int busy_cnt;
      s_before = s;
      busy_cnt = 0;
      drive_op(va[i], vb[i], vsb[i]);
      for (int cyc = 1; cyc <= 8; cyc++) begin
        if (busy) busy_cnt++;
        tests++;
        if (done !== 1'b0 || s !== s_before) begin
          fails++;
          $display("FAIL dir%0d_calc_cycle%0d: got done=%b s=%h, expected done=0 s=%h",
                   i, cyc, done, s, s_before);
        end
        @(posedge clk);
        #1;
      end
      tests++;
      if (busy_cnt != 8) begin
        fails++;
        $display("FAIL dir%0d_busy_cycles: got %0d expected 8", i, busy_cnt);
      end
      tests++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        fails++;
        $display("FAIL dir%0d_done_cycle9: got done=%b busy=%b, expected done=1 busy=0",
                 i, done, busy);
      end
      tests++;
      if (s !== vs[i] || cout !== vc[i] || overflow !== vv[i]) begin
        fails++;
        $display("FAIL dir%0d_result: got s=%h cout=%b ovf=%b, expected s=%h cout=%b ovf=%b",
                 i, s, cout, overflow, vs[i], vc[i], vv[i]);
      end
      @(posedge clk);
      #1;
      tests++;
      if (done !== 1'b0 || state_dbg !== IDLE) begin
        fails++;
        $display("FAIL dir%0d_done_pulse: got done=%b state=%0d, expected done=0 state=%0d",
                 i, done, state_dbg, IDLE);
      end
    end
  endtask

  task automatic test_ignored_start();
    int n_done;
    int done_cyc;
    logic [W-1:0] s_at_done;
    n_done    = 0;
    done_cyc  = -1;
    s_at_done = '0;
    drive_op(8'h01, 8'h01, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    // Now in CALC cycle 3: raise a conflicting request for one edge.
    a     = 8'hAA;
    b     = 8'h55;
    sub   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int cyc = 4; cyc <= 24; cyc++) begin
      if (done) begin
        n_done++;
        done_cyc  = cyc;
        s_at_done = s;
      end
      @(posedge clk);
      #1;
    end
    tests++;
    if (n_done != 1 || done_cyc != 9) begin
      fails++;
      $display("FAIL ignored_start_done: got %0d pulses last at cycle %0d, expected 1 at cycle 9",
               n_done, done_cyc);
    end
    tests++;
    if (s_at_done !== 8'h02 || s !== 8'h02) begin
      fails++;
      $display("FAIL ignored_start_result: got s=%h (final %h) expected 02", s_at_done, s);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic saw_done;
    saw_done = 1'b0;
    // Leave non-zero cout/overflow/s behind so the reset clear is visible.
    drive_op(8'h80, 8'h01, 1'b1);
    wait_done(cyc);
    @(posedge clk);
    #1;
    drive_op(8'h33, 8'h44, 1'b0);
    for (int k = 1; k < 4; k++) begin
      if (done) saw_done = 1'b1;
      @(posedge clk);
      #1;
    end
    // CALC cycle 4: assert reset away from the clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({s, cout, overflow, busy, done} !== '0 || state_dbg !== IDLE) begin
      fails++;
      $display("FAIL reset_mid_immediate: got s=%h cout=%b ovf=%b busy=%b done=%b state=%0d, expected all 0",
               s, cout, overflow, busy, done, state_dbg);
    end
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1'b1;
    end
    tests++;
    if (saw_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_no_done: got activity=1 expected 0");
    end
    drive_op(8'h10, 8'h20, 1'b0);
    wait_done(cyc);
    tests++;
    if (cyc != 9 || s !== 8'h30 || cout !== 1'b0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_after: got cycle=%0d s=%h cout=%b ovf=%b, expected cycle=9 s=30 cout=0 ovf=0",
               cyc, s, cout, overflow);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int cyc;
    int cyc2;
    logic [W+1:0] exp1;
    // Hold start high throughout: the second request is taken only after DONE->IDLE.
    drive_op(8'h11, 8'h22, 1'b0);
    start = 1'b1;
    wait_done(cyc);
    tests++;
    if (cyc != 9 || s !== 8'h33) begin
      fails++;
      $display("FAIL b2b_first: got cycle=%0d s=%h expected cycle=9 s=33", cyc, s);
    end
    a   = 8'hC8;
    b   = 8'h64;
    sub = 1'b0;
    exp1 = ref_op(8'hC8, 8'h64, 1'b0);
    @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || state_dbg !== IDLE) begin
      fails++;
      $display("FAIL b2b_gap: got busy=%b done=%b state=%0d, expected 0 0 %0d",
               busy, done, state_dbg, IDLE);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc2);
    tests++;
    if (cyc2 != 9 || {overflow, cout, s} !== exp1) begin
      fails++;
      $display("FAIL b2b_second: got cycle=%0d {v,c,s}=%h expected cycle=9 %h", cyc2,
               {overflow, cout, s}, exp1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int local_fail;
    local_fail = 0;
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra, rb;
      logic rsub;
      logic [W+1:0] exp_v;
      int cyc;
      ra    = W'($urandom_range(0, (1 << W) - 1));
      rb    = W'($urandom_range(0, (1 << W) - 1));
      rsub  = 1'($urandom_range(0, 1));
      exp_v = ref_op(ra, rb, rsub);
      drive_op(ra, rb, rsub);
      wait_done(cyc);
      tests++;
      if (cyc != 9 || {overflow, cout, s} !== exp_v) begin
        fails++;
        local_fail++;
        if (local_fail <= 10)
          $display("FAIL random_%0d: a=%h b=%h sub=%b got cycle=%0d {v,c,s}=%h expected cycle=9 %h",
                   i, ra, rb, rsub, cyc, {overflow, cout, s}, exp_v);
      end
      @(posedge clk);
      #1;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_directed();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
